// File: rtl/cpu_pkg.sv
// Shared encodings for the parametrised datapath: ALU opcodes, bus selects,
// CCR flag positions and the memory-wait state machine states.
package cpu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_ADC = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_SBC = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b101;
    localparam logic [2:0] ALU_XOR = 3'b110;
    localparam logic [2:0] ALU_NOT = 3'b111;

    localparam logic [1:0] BUS1_PC = 2'b00;
    localparam logic [1:0] BUS1_RA = 2'b01;
    localparam logic [1:0] BUS1_RB = 2'b10;
    localparam logic [1:0] BUS1_IR = 2'b11;

    localparam logic [1:0] BUS2_ALU  = 2'b00;
    localparam logic [1:0] BUS2_BUS1 = 2'b01;
    localparam logic [1:0] BUS2_MEM  = 2'b10;
    localparam logic [1:0] BUS2_ZERO = 2'b11;

    // CCR_Result is {N,Z,V,C}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/param_alu.sv
// Combinational ALU with N/Z/V/C flag generation; zero latency, no flow control.
// For subtracts C is a borrow: set when a < b + cin as unsigned values.
module param_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [2:0]        op_i,
    input  logic              cin_i,
    output logic [DATA_W-1:0] result_o,
    output logic [3:0]        flags_o
);

    localparam int MSB = DATA_W - 1;

    logic [DATA_W:0]   wide;
    logic [DATA_W:0]   cext;
    logic [DATA_W-1:0] res;
    logic              flag_v;
    logic              flag_c;

    always_comb begin
        wide   = '0;
        cext   = '0;
        res    = '0;
        flag_v = 1'b0;
        flag_c = 1'b0;
        case (op_i)
            ALU_ADD, ALU_ADC: begin
                cext[0] = (op_i == ALU_ADC) ? cin_i : 1'b0;
                wide    = {1'b0, a_i} + {1'b0, b_i} + cext;
                res     = wide[DATA_W-1:0];
                flag_c  = wide[DATA_W];
                flag_v  = (a_i[MSB] == b_i[MSB]) && (res[MSB] != a_i[MSB]);
            end
            ALU_SUB, ALU_SBC: begin
                // The extra top bit goes negative exactly when a < b + borrow-in
                cext[0] = (op_i == ALU_SBC) ? cin_i : 1'b0;
                wide    = {1'b0, a_i} - {1'b0, b_i} - cext;
                res     = wide[DATA_W-1:0];
                flag_c  = wide[DATA_W];
                flag_v  = (a_i[MSB] != b_i[MSB]) && (res[MSB] != a_i[MSB]);
            end
            ALU_AND: res = a_i & b_i;
            ALU_OR:  res = a_i | b_i;
            ALU_XOR: res = a_i ^ b_i;
            default: res = ~a_i;
        endcase
    end

    assign result_o       = res;
    assign flags_o[FLAG_N] = res[MSB];
    assign flags_o[FLAG_Z] = (res == '0);
    assign flags_o[FLAG_V] = flag_v;
    assign flags_o[FLAG_C] = flag_c;

endmodule

// File: rtl/param_data_path.sv
// Parametrised CPU datapath: two buses, register file, ALU, PC/MAR/IR/CCR.
// Loads from memory without mem_valid stall in WAIT, ignoring new strobes, until data or timeout.
module param_data_path
    import cpu_pkg::*;
#(
    parameter int  DATA_W   = 8,
    parameter int  ADDR_W   = 8,
    parameter int  NUM_REGS = 4,
    parameter int  WAIT_MAX = 15,
    localparam int RSEL_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] from_memory,
    input  logic              mem_valid,
    input  logic [2:0]        ALU_Sel,
    input  logic [1:0]        Bus1_Sel,
    input  logic [1:0]        Bus2_Sel,
    input  logic [RSEL_W-1:0] Ra_Sel,
    input  logic [RSEL_W-1:0] Rb_Sel,
    input  logic [RSEL_W-1:0] Rd_Sel,
    input  logic              IR_Load,
    input  logic              MAR_Load,
    input  logic              PC_Load,
    input  logic              Reg_Load,
    input  logic              CCR_Load,
    input  logic              PC_Inc,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] to_memory,
    output logic [DATA_W-1:0] IR_out,
    output logic [3:0]        CCR_Result,
    output logic              mem_wait,
    output logic              mem_err
);

    localparam int                CNT_W    = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WAIT_MAX - 1);

    logic [DATA_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [3:0]        ccr_q, ccr_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];

    state_e            state_q;
    logic [CNT_W-1:0]  wait_cnt_q;
    logic              mem_wait_q;
    logic              mem_err_q;
    logic              pend_ir_q, pend_mar_q, pend_pc_q, pend_reg_q;
    logic [RSEL_W-1:0] pend_rd_q;

    logic [DATA_W-1:0] ra_val, rb_val;
    logic [DATA_W-1:0] alu_res;
    logic [3:0]        alu_flags;
    logic [DATA_W-1:0] bus1, bus2;
    logic [DATA_W-1:0] pc_ext;
    logic [DATA_W-1:0] wr_dat;
    logic [ADDR_W-1:0] wr_addr;
    logic [RSEL_W-1:0] rd_idx;
    logic              in_idle, any_load, stall, take, fill;
    logic              ir_we, mar_we, pc_we, reg_we;

    always_comb begin
        ra_val = '0;
        rb_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (Ra_Sel == RSEL_W'(i)) ra_val = regs_q[i];
            if (Rb_Sel == RSEL_W'(i)) rb_val = regs_q[i];
        end
    end

    param_alu #(.DATA_W(DATA_W)) u_alu (
        .a_i      (ra_val),
        .b_i      (rb_val),
        .op_i     (ALU_Sel),
        .cin_i    (ccr_q[FLAG_C]),
        .result_o (alu_res),
        .flags_o  (alu_flags)
    );

    if (ADDR_W >= DATA_W) begin : g_pc_trunc
        assign pc_ext = pc_q[DATA_W-1:0];
    end else begin : g_pc_zext
        assign pc_ext = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
    end

    always_comb begin
        case (Bus1_Sel)
            BUS1_PC: bus1 = pc_ext;
            BUS1_RA: bus1 = ra_val;
            BUS1_RB: bus1 = rb_val;
            default: bus1 = ir_q;
        endcase
    end

    always_comb begin
        case (Bus2_Sel)
            BUS2_ALU:  bus2 = alu_res;
            BUS2_BUS1: bus2 = bus1;
            BUS2_MEM:  bus2 = from_memory;
            default:   bus2 = '0;
        endcase
    end

    // take: new strobes accepted this edge; fill: the pending memory load completes
    assign in_idle  = (state_q == ST_IDLE);
    assign any_load = IR_Load | MAR_Load | PC_Load | Reg_Load;
    assign stall    = in_idle && (Bus2_Sel == BUS2_MEM) && any_load && !mem_valid;
    assign take     = in_idle && !stall;
    assign fill     = !in_idle && mem_valid;

    assign wr_dat = in_idle ? bus2 : from_memory;
    assign rd_idx = in_idle ? Rd_Sel : pend_rd_q;

    if (ADDR_W <= DATA_W) begin : g_wa_trunc
        assign wr_addr = wr_dat[ADDR_W-1:0];
    end else begin : g_wa_zext
        assign wr_addr = {{(ADDR_W-DATA_W){1'b0}}, wr_dat};
    end

    assign ir_we  = (take && IR_Load)  || (fill && pend_ir_q);
    assign mar_we = (take && MAR_Load) || (fill && pend_mar_q);
    assign pc_we  = (take && PC_Load)  || (fill && pend_pc_q);
    assign reg_we = (take && Reg_Load) || (fill && pend_reg_q);

    always_comb begin
        ir_d  = ir_we  ? wr_dat  : ir_q;
        mar_d = mar_we ? wr_addr : mar_q;
        pc_d  = pc_q;
        if (pc_we) begin
            pc_d = wr_addr;
        end else if (take && PC_Inc) begin
            pc_d = pc_q + ADDR_W'(1);
        end
        ccr_d = (take && CCR_Load) ? alu_flags : ccr_q;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ir_q  <= '0;
            mar_q <= '0;
            pc_q  <= '0;
            ccr_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            ir_q  <= ir_d;
            mar_q <= mar_d;
            pc_q  <= pc_d;
            ccr_q <= ccr_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (reg_we && (rd_idx == RSEL_W'(i))) regs_q[i] <= wr_dat;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            mem_wait_q <= 1'b0;
            mem_err_q  <= 1'b0;
            pend_ir_q  <= 1'b0;
            pend_mar_q <= 1'b0;
            pend_pc_q  <= 1'b0;
            pend_reg_q <= 1'b0;
            pend_rd_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (stall) begin
                        state_q    <= ST_WAIT;
                        mem_wait_q <= 1'b1;
                        wait_cnt_q <= '0;
                        pend_ir_q  <= IR_Load;
                        pend_mar_q <= MAR_Load;
                        pend_pc_q  <= PC_Load;
                        pend_reg_q <= Reg_Load;
                        pend_rd_q  <= Rd_Sel;
                    end
                end
                ST_WAIT: begin
                    if (mem_valid) begin
                        state_q    <= ST_IDLE;
                        mem_wait_q <= 1'b0;
                    end else if (wait_cnt_q == CNT_LAST) begin
                        state_q    <= ST_IDLE;
                        mem_wait_q <= 1'b0;
                        mem_err_q  <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    mem_wait_q <= 1'b0;
                end
            endcase
        end
    end

    assign address    = mar_q;
    assign to_memory  = bus1;
    assign IR_out     = ir_q;
    assign CCR_Result = ccr_q;
    assign mem_wait   = mem_wait_q;
    assign mem_err    = mem_err_q;

endmodule

// File: tb/tb_param_data_path.sv
// Directed bench: stimulus queues expected observations tagged with a due cycle;
// a negedge monitor compares each one when its cycle arrives.
module tb_param_data_path;
    import cpu_pkg::*;

    localparam int S_IR = 0, S_CCR = 1, S_ADDR = 2, S_BUS1 = 3, S_WAIT = 4, S_ERR = 5;

    logic       Clk;
    logic       Reset;
    logic [7:0] from_memory;
    logic       mem_valid;
    logic [2:0] ALU_Sel;
    logic [1:0] Bus1_Sel, Bus2_Sel;
    logic [1:0] Ra_Sel, Rb_Sel, Rd_Sel;
    logic       IR_Load, MAR_Load, PC_Load, Reg_Load, CCR_Load, PC_Inc;
    logic [7:0] address, to_memory, IR_out;
    logic [3:0] CCR_Result;
    logic       mem_wait, mem_err;

    typedef struct {
        string      nm;
        int         sig;
        logic [7:0] val;
        int         due;
    } chk_t;

    chk_t sb[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    param_data_path #(.DATA_W(8), .ADDR_W(8), .NUM_REGS(4), .WAIT_MAX(4)) dut (
        .Clk(Clk), .Reset(Reset), .from_memory(from_memory), .mem_valid(mem_valid),
        .ALU_Sel(ALU_Sel), .Bus1_Sel(Bus1_Sel), .Bus2_Sel(Bus2_Sel),
        .Ra_Sel(Ra_Sel), .Rb_Sel(Rb_Sel), .Rd_Sel(Rd_Sel),
        .IR_Load(IR_Load), .MAR_Load(MAR_Load), .PC_Load(PC_Load), .Reg_Load(Reg_Load),
        .CCR_Load(CCR_Load), .PC_Inc(PC_Inc),
        .address(address), .to_memory(to_memory), .IR_out(IR_out),
        .CCR_Result(CCR_Result), .mem_wait(mem_wait), .mem_err(mem_err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    function automatic logic [7:0] observe(input int sig);
        case (sig)
            S_IR:    return IR_out;
            S_CCR:   return {4'b0, CCR_Result};
            S_ADDR:  return address;
            S_BUS1:  return to_memory;
            S_WAIT:  return {7'b0, mem_wait};
            S_ERR:   return {7'b0, mem_err};
            default: return 8'h00;
        endcase
    endfunction

    always @(negedge Clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due <= cyc) begin
                total++;
                if (sb[i].due < cyc) begin
                    bad++;
                    $display("FAIL %s: not sampled in its cycle, required %0h", sb[i].nm, sb[i].val);
                end else if (observe(sb[i].sig) !== sb[i].val) begin
                    bad++;
                    $display("FAIL %s: got %0h required %0h", sb[i].nm, observe(sb[i].sig), sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    // lat 0: sampled this cycle (combinational/async); lat 1: after the next edge
    task automatic chk(input string nm, input int sig, input logic [7:0] val, input int lat);
        chk_t c;
        c.nm  = nm;
        c.sig = sig;
        c.val = val;
        c.due = cyc + lat;
        sb.push_back(c);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        from_memory = 8'h00; mem_valid = 1'b0;
        ALU_Sel = ALU_ADD; Bus1_Sel = BUS1_PC; Bus2_Sel = BUS2_ALU;
        Ra_Sel = 2'd0; Rb_Sel = 2'd0; Rd_Sel = 2'd0;
        IR_Load = 1'b0; MAR_Load = 1'b0; PC_Load = 1'b0;
        Reg_Load = 1'b0; CCR_Load = 1'b0; PC_Inc = 1'b0;
    endtask

    task automatic alu_op(input string nm, input logic [2:0] op, input logic [1:0] ra,
                          input logic [1:0] rb, input logic [7:0] res, input logic [7:0] ccr);
        idle_inputs();
        ALU_Sel = op; Ra_Sel = ra; Rb_Sel = rb;
        Bus2_Sel = BUS2_ALU; IR_Load = 1'b1; CCR_Load = 1'b1;
        chk({nm, "_res"}, S_IR, res, 1);
        chk({nm, "_ccr"}, S_CCR, ccr, 1);
        step();
    endtask

    task automatic wait_strobes();
        idle_inputs();
        MAR_Load = 1'b1; PC_Load = 1'b1; Reg_Load = 1'b1; Rd_Sel = 2'd1;
        CCR_Load = 1'b1; PC_Inc = 1'b1; Bus2_Sel = BUS2_ZERO;
        ALU_Sel = ALU_AND; Ra_Sel = 2'd1; Rb_Sel = 2'd1;
    endtask

    initial begin
        Reset = 1'b1;
        idle_inputs();
        step();
        chk("rst_ir", S_IR, 8'h00, 0);
        chk("rst_ccr", S_CCR, 8'h00, 0);
        chk("rst_addr", S_ADDR, 8'h00, 0);
        chk("rst_pc", S_BUS1, 8'h00, 0);
        chk("rst_wait", S_WAIT, 8'h00, 0);
        chk("rst_err", S_ERR, 8'h00, 0);
        step();
        Reset = 1'b0;
        step();

        // R1 = 0x18, R2 = 0xBB straight from memory
        Bus2_Sel = BUS2_MEM; mem_valid = 1'b1; Reg_Load = 1'b1;
        Rd_Sel = 2'd1; from_memory = 8'h18; step();
        Rd_Sel = 2'd2; from_memory = 8'hBB; step();

        idle_inputs();
        Ra_Sel = 2'd1; Rb_Sel = 2'd2; Bus1_Sel = BUS1_RA;
        IR_Load = 1'b1; CCR_Load = 1'b1; ALU_Sel = ALU_ADD;
        chk("bus1_r1", S_BUS1, 8'h18, 0);
        chk("add_res", S_IR, 8'hD3, 1);
        chk("add_ccr", S_CCR, 8'h08, 1);
        step();
        ALU_Sel = ALU_SUB; Bus1_Sel = BUS1_RB;
        chk("bus1_r2", S_BUS1, 8'hBB, 0);
        chk("sub_res", S_IR, 8'h5D, 1);
        chk("sub_ccr", S_CCR, 8'h01, 1);
        step();
        ALU_Sel = ALU_SBC; CCR_Load = 1'b0; Bus1_Sel = BUS1_IR;
        chk("bus1_ir", S_BUS1, 8'h5D, 0);
        chk("sbc_res", S_IR, 8'h5C, 1);
        chk("sbc_ccr_held", S_CCR, 8'h01, 1);
        step();

        alu_op("add_ovf", ALU_ADD, 2'd2, 2'd2, 8'h76, 8'h03);
        alu_op("adc_c1", ALU_ADC, 2'd1, 2'd2, 8'hD4, 8'h08);
        alu_op("sub_zero", ALU_SUB, 2'd1, 2'd1, 8'h00, 8'h04);
        alu_op("xor", ALU_XOR, 2'd1, 2'd2, 8'hA3, 8'h08);
        alu_op("and", ALU_AND, 2'd1, 2'd2, 8'h18, 8'h00);
        alu_op("not", ALU_NOT, 2'd1, 2'd2, 8'hE7, 8'h08);

        idle_inputs();
        Bus1_Sel = BUS1_RB; Rb_Sel = 2'd2; Bus2_Sel = BUS2_BUS1; MAR_Load = 1'b1;
        chk("mar_bus1", S_ADDR, 8'hBB, 1);
        step();

        // memory answers on the third cycle; strobes issued meanwhile must be dropped
        idle_inputs();
        IR_Load = 1'b1; Bus2_Sel = BUS2_MEM; from_memory = 8'h99;
        chk("wait_before", S_WAIT, 8'h00, 0);
        step();
        wait_strobes();
        chk("wait_c1", S_WAIT, 8'h01, 0);
        step();
        wait_strobes();
        chk("wait_c2", S_WAIT, 8'h01, 0);
        step();
        wait_strobes();
        mem_valid = 1'b1; from_memory = 8'h45;
        chk("wait_c3", S_WAIT, 8'h01, 0);
        chk("wait_ir", S_IR, 8'h45, 1);
        chk("wait_done", S_WAIT, 8'h00, 1);
        chk("wait_mar_held", S_ADDR, 8'hBB, 1);
        chk("wait_ccr_held", S_CCR, 8'h08, 1);
        step();
        idle_inputs();
        Bus1_Sel = BUS1_RA; Ra_Sel = 2'd1;
        chk("wait_r1_held", S_BUS1, 8'h18, 0);
        step();
        idle_inputs();
        chk("wait_pc_held", S_BUS1, 8'h00, 0);
        step();

        // memory never answers: abort after four wait cycles
        IR_Load = 1'b1; Bus2_Sel = BUS2_MEM; from_memory = 8'h77;
        step();
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            chk($sformatf("tmo_wait%0d", i), S_WAIT, 8'h01, 0);
            step();
        end
        chk("tmo_cleared", S_WAIT, 8'h00, 0);
        chk("tmo_err", S_ERR, 8'h01, 0);
        chk("tmo_ir_held", S_IR, 8'h45, 0);
        mem_valid = 1'b1; from_memory = 8'h88;
        chk("tmo_late_valid", S_IR, 8'h45, 1);
        step();
        idle_inputs();
        IR_Load = 1'b1; Bus2_Sel = BUS2_MEM; mem_valid = 1'b1; from_memory = 8'h3C;
        chk("err_nonblock_ir", S_IR, 8'h3C, 1);
        chk("err_sticky", S_ERR, 8'h01, 1);
        chk("err_no_wait", S_WAIT, 8'h00, 1);
        step();

        // PC wrap and load-over-increment priority
        idle_inputs();
        PC_Load = 1'b1; Bus2_Sel = BUS2_MEM; mem_valid = 1'b1; from_memory = 8'hFF;
        step();
        idle_inputs();
        chk("pc_ff", S_BUS1, 8'hFF, 0);
        PC_Inc = 1'b1;
        step();
        idle_inputs();
        chk("pc_wrap", S_BUS1, 8'h00, 0);
        PC_Load = 1'b1; PC_Inc = 1'b1; Bus2_Sel = BUS2_MEM; mem_valid = 1'b1; from_memory = 8'h10;
        step();
        idle_inputs();
        chk("pc_load_prio", S_BUS1, 8'h10, 0);
        PC_Inc = 1'b1;
        step();
        idle_inputs();
        chk("pc_inc", S_BUS1, 8'h11, 0);
        step();

        // asynchronous reset in the middle of a wait
        IR_Load = 1'b1; Bus2_Sel = BUS2_MEM; from_memory = 8'h55;
        step();
        idle_inputs();
        chk("rw_pending", S_WAIT, 8'h01, 0);
        step();
        Reset = 1'b1;
        chk("rw_ir", S_IR, 8'h00, 0);
        chk("rw_ccr", S_CCR, 8'h00, 0);
        chk("rw_addr", S_ADDR, 8'h00, 0);
        chk("rw_pc", S_BUS1, 8'h00, 0);
        chk("rw_wait", S_WAIT, 8'h00, 0);
        chk("rw_err", S_ERR, 8'h00, 0);
        step();
        Reset = 1'b0;
        mem_valid = 1'b1; from_memory = 8'h66;
        chk("rw_late_ir", S_IR, 8'h00, 1);
        chk("rw_late_wait", S_WAIT, 8'h00, 1);
        step();
        idle_inputs();
        Bus1_Sel = BUS1_RA; Ra_Sel = 2'd1;
        chk("rw_r1_clear", S_BUS1, 8'h00, 0);
        step();
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
